// File: rtl/game_pkg.sv
// Shared types and width helpers for the tank-arena match controller and
// the score overlay that reads its packed score bus.
package game_pkg;

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        PLAYING  = 2'd1,
        CONTINUE = 2'd2,
        FINAL    = 2'd3
    } game_state_t;

    localparam int SCORE_BITS_DEF = 6;
    localparam int MAX_TARGET_DEF = 9;

    // Pause counter width; never narrower than one bit so a zero pause still has a flop.
    function automatic int pause_w(input int frames);
        int w;
        w = $clog2(frames + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot renderer flags ordered {final, continue, playing, menu}.
    function automatic logic [3:0] state_flags(input game_state_t s);
        logic [3:0] f;
        case (s)
            MENU:     f = 4'b0001;
            PLAYING:  f = 4'b0010;
            CONTINUE: f = 4'b0100;
            FINAL:    f = 4'b1000;
            default:  f = 4'b0001;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/match_fsm_if.sv
// Button, hit and frame inputs plus renderer/overlay outputs of the match controller.
interface match_fsm_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_BITS  = 6
);
    logic                              start_i;
    logic                              sel_up_i;
    logic                              sel_down_i;
    logic [NUM_PLAYERS-1:0]            hit_i;
    logic                              frame_tick_i;
    logic                              is_menu_o;
    logic                              is_playing_o;
    logic                              is_continue_o;
    logic                              is_final_o;
    logic                              round_reset_o;
    logic [NUM_PLAYERS*SCORE_BITS-1:0] score_o;
    logic [SCORE_BITS-1:0]             target_o;
    logic [NUM_PLAYERS-1:0]            winner_o;

    modport slave (
        input  start_i, sel_up_i, sel_down_i, hit_i, frame_tick_i,
        output is_menu_o, is_playing_o, is_continue_o, is_final_o,
               round_reset_o, score_o, target_o, winner_o
    );

    modport master (
        output start_i, sel_up_i, sel_down_i, hit_i, frame_tick_i,
        input  is_menu_o, is_playing_o, is_continue_o, is_final_o,
               round_reset_o, score_o, target_o, winner_o
    );
endinterface

// File: rtl/btn_edge.sv
// Registered rising-edge detector; history resets high so a button held
// through reset never produces a spurious press.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic level_r;
    logic prev_r;

    // Sample the button and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            level_r <= level;
            prev_r  <= level_r;
        end
    end

    assign rise = level_r & ~prev_r;
endmodule

// File: rtl/match_fsm.sv
// Match controller: menu target selection, per-player saturating scores,
// frame-counted pause between rounds and the round-reset strobe.
module match_fsm
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int SCORE_BITS     = SCORE_BITS_DEF,
    parameter int MAX_TARGET     = MAX_TARGET_DEF,
    parameter int DEFAULT_TARGET = 5,
    parameter int PAUSE_FRAMES   = 120
) (
    input  logic         clk_i,
    input  logic         reset_i,
    match_fsm_if.slave   bus
);
    localparam int PW = pause_w(PAUSE_FRAMES);

    logic start_rise_s;
    logic up_rise_s;
    logic down_rise_s;

    game_state_t                            state_r, state_s;
    logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0] score_r, score_s;
    logic [SCORE_BITS-1:0]                  target_r, target_s;
    logic [PW-1:0]                          pause_r, pause_s;
    logic [NUM_PLAYERS-1:0]                 winner_r, winner_s, reached_s;
    logic                                   any_reach_s;
    logic                                   round_reset_r, round_reset_s;
    logic [3:0]                             flags_r;

    btn_edge u_start (.clk(clk_i), .reset(reset_i), .level(bus.start_i),    .rise(start_rise_s));
    btn_edge u_up    (.clk(clk_i), .reset(reset_i), .level(bus.sel_up_i),   .rise(up_rise_s));
    btn_edge u_down  (.clk(clk_i), .reset(reset_i), .level(bus.sel_down_i), .rise(down_rise_s));

    // Next-state, score, target and pause logic.
    always_comb begin
        state_s     = state_r;
        score_s     = score_r;
        target_s    = target_r;
        pause_s     = pause_r;
        any_reach_s = 1'b0;
        case (state_r)
            MENU: begin
                if (start_rise_s) begin
                    score_s = '0;
                    state_s = PLAYING;
                end else if (up_rise_s && !down_rise_s) begin
                    if (target_r != SCORE_BITS'(MAX_TARGET)) target_s = target_r + SCORE_BITS'(1);
                    else                                     target_s = target_r;
                end else if (down_rise_s && !up_rise_s) begin
                    if (target_r > SCORE_BITS'(1)) target_s = target_r - SCORE_BITS'(1);
                    else                           target_s = target_r;
                end else begin
                    target_s = target_r;
                end
            end
            PLAYING: begin
                if (|bus.hit_i) begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        if (bus.hit_i[k] && (score_r[k] != {SCORE_BITS{1'b1}}))
                            score_s[k] = score_r[k] + SCORE_BITS'(1);
                        else
                            score_s[k] = score_r[k];
                        any_reach_s = any_reach_s | (score_s[k] >= target_r);
                    end
                    if (any_reach_s) begin
                        state_s = FINAL;
                    end else begin
                        state_s = CONTINUE;
                        pause_s = PW'(PAUSE_FRAMES);
                    end
                end else begin
                    state_s = PLAYING;
                end
            end
            CONTINUE: begin
                // A skip press beats a frame tick landing in the same cycle.
                if (start_rise_s || (pause_r == PW'(0))) state_s = PLAYING;
                else if (bus.frame_tick_i)                pause_s = pause_r - PW'(1);
                else                                      pause_s = pause_r;
            end
            FINAL: begin
                if (start_rise_s) state_s = MENU;
                else              state_s = FINAL;
            end
            default: state_s = MENU;
        endcase

        for (int k = 0; k < NUM_PLAYERS; k++) begin
            reached_s[k] = (score_s[k] >= target_r);
        end
        winner_s      = (state_s == FINAL) ? reached_s : '0;
        round_reset_s = (state_s == MENU) || (state_s == FINAL) ||
                        ((state_s == PLAYING) && (state_r != PLAYING));
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= MENU;
            score_r       <= '0;
            target_r      <= SCORE_BITS'(DEFAULT_TARGET);
            pause_r       <= '0;
            winner_r      <= '0;
            round_reset_r <= 1'b1;
            flags_r       <= 4'b0001;
        end else begin
            state_r       <= state_s;
            score_r       <= score_s;
            target_r      <= target_s;
            pause_r       <= pause_s;
            winner_r      <= winner_s;
            round_reset_r <= round_reset_s;
            flags_r       <= state_flags(state_s);
        end
    end

    assign bus.is_menu_o     = flags_r[0];
    assign bus.is_playing_o  = flags_r[1];
    assign bus.is_continue_o = flags_r[2];
    assign bus.is_final_o    = flags_r[3];
    assign bus.round_reset_o = round_reset_r;
    assign bus.score_o       = score_r;
    assign bus.target_o      = target_r;
    assign bus.winner_o      = winner_r;
endmodule

// File: tb/tb_match_fsm.sv
// Directed and random bench for match_fsm: two instances (pause 3 and pause 0)
// share stimulus and are compared each cycle against a behavioural match model.
module tb_match_fsm;
    localparam int NP = 2;
    localparam int SB = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, up = 1'b0, down = 1'b0, frame_tick = 1'b0;
    logic [NP-1:0] hit = '0;
    int            total = 0;
    int            bad = 0;

    match_fsm_if #(.NUM_PLAYERS(NP), .SCORE_BITS(SB)) bus0 ();
    match_fsm_if #(.NUM_PLAYERS(NP), .SCORE_BITS(SB)) bus1 ();

    assign bus0.start_i = start;  assign bus0.sel_up_i = up;  assign bus0.sel_down_i = down;
    assign bus0.hit_i   = hit;    assign bus0.frame_tick_i = frame_tick;
    assign bus1.start_i = start;  assign bus1.sel_up_i = up;  assign bus1.sel_down_i = down;
    assign bus1.hit_i   = hit;    assign bus1.frame_tick_i = frame_tick;

    match_fsm #(.NUM_PLAYERS(NP), .SCORE_BITS(SB), .MAX_TARGET(9), .DEFAULT_TARGET(5),
                .PAUSE_FRAMES(3)) u_dut (.clk_i(clk), .reset_i(reset), .bus(bus0));
    match_fsm #(.NUM_PLAYERS(NP), .SCORE_BITS(SB), .MAX_TARGET(9), .DEFAULT_TARGET(5),
                .PAUSE_FRAMES(0)) u_dut_nopause (.clk_i(clk), .reset_i(reset), .bus(bus1));

    always #5 clk = ~clk;

    // Behavioural model: phase 0 menu, 1 playing, 2 pause, 3 final.
    int m_phase[2], m_target[2], m_pause[2];
    int m_score[2][NP];
    bit m_rr[2];
    bit m_lvl[3], m_prev[3];

    function automatic int pause_of(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    task automatic model_step();
        bit st, su, sd, any, reach;
        int old;
        st = m_lvl[0] && !m_prev[0];
        su = m_lvl[1] && !m_prev[1];
        sd = m_lvl[2] && !m_prev[2];
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] = 0; m_target[i] = 5; m_pause[i] = 0; m_rr[i] = 1'b1;
                for (int k = 0; k < NP; k++) m_score[i][k] = 0;
                continue;
            end
            old = m_phase[i];
            any = |hit;
            case (m_phase[i])
                0: if (st) begin
                       m_phase[i] = 1;
                       for (int k = 0; k < NP; k++) m_score[i][k] = 0;
                   end else if (su && !sd) m_target[i] = (m_target[i] < 9) ? m_target[i] + 1 : 9;
                   else if (sd && !su)     m_target[i] = (m_target[i] > 1) ? m_target[i] - 1 : 1;
                1: if (any) begin
                       reach = 1'b0;
                       for (int k = 0; k < NP; k++) begin
                           if (hit[k] && m_score[i][k] < 63) m_score[i][k]++;
                           if (m_score[i][k] >= m_target[i]) reach = 1'b1;
                       end
                       m_phase[i] = reach ? 3 : 2;
                       if (!reach) m_pause[i] = pause_of(i);
                   end
                2: if (st || m_pause[i] == 0) m_phase[i] = 1;
                   else if (frame_tick)       m_pause[i]--;
                default: if (st) m_phase[i] = 0;
            endcase
            m_rr[i] = (m_phase[i] == 0) || (m_phase[i] == 3) || (m_phase[i] == 1 && old != 1);
        end
        if (reset) begin
            m_lvl = '{1'b1, 1'b1, 1'b1}; m_prev = '{1'b1, 1'b1, 1'b1};
        end else begin
            m_prev = m_lvl;
            m_lvl  = '{start, up, down};
        end
    endtask

    task automatic expect_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int i, input logic [3:0] flags, input logic rr,
                           input logic [NP*SB-1:0] sc, input logic [SB-1:0] tg, input logic [NP-1:0] wn);
        logic [NP*SB-1:0] e_sc;
        logic [NP-1:0]    e_wn;
        for (int k = 0; k < NP; k++) begin
            e_sc[k*SB +: SB] = SB'(m_score[i][k]);
            e_wn[k] = (m_phase[i] == 3) && (m_score[i][k] >= m_target[i]);
        end
        expect_v($sformatf("flags%0d", i), 32'(flags), 32'(4'b0001 << m_phase[i]));
        expect_v($sformatf("round_reset%0d", i), 32'(rr), 32'(m_rr[i]));
        expect_v($sformatf("score%0d", i), 32'(sc), 32'(e_sc));
        expect_v($sformatf("target%0d", i), 32'(tg), 32'(m_target[i]));
        expect_v($sformatf("winner%0d", i), 32'(wn), 32'(e_wn));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk_dut(0, {bus0.is_final_o, bus0.is_continue_o, bus0.is_playing_o, bus0.is_menu_o},
                bus0.round_reset_o, bus0.score_o, bus0.target_o, bus0.winner_o);
        chk_dut(1, {bus1.is_final_o, bus1.is_continue_o, bus1.is_playing_o, bus1.is_menu_o},
                bus1.round_reset_o, bus1.score_o, bus1.target_o, bus1.winner_o);
    endtask

    // which: 0 start, 1 up, 2 down, 3 up+down together
    task automatic press(input int which);
        start = (which == 0); up = (which == 1 || which == 3); down = (which == 2 || which == 3);
        tick();
        start = 1'b0; up = 1'b0; down = 1'b0;
        tick();
    endtask

    task automatic wait_play();
        int n = 0;
        frame_tick = 1'b1;
        while (!bus0.is_playing_o && n < 20) begin
            tick();
            n++;
        end
        frame_tick = 1'b0;
        expect_v("wait_play", 32'(bus0.is_playing_o), 32'd1);
    endtask

    task automatic hit_once(input logic [NP-1:0] h);
        hit = h;
        tick();
        hit = '0;
    endtask

    initial begin
        // Reset with start held, then a held press after reset must not fire.
        start = 1'b1;
        repeat (3) tick();
        expect_v("reset_target", 32'(bus0.target_o), 32'd5);
        expect_v("reset_rr", 32'(bus0.round_reset_o), 32'd1);
        reset = 1'b0;
        repeat (3) tick();
        expect_v("held_start_menu", 32'(bus0.is_menu_o), 32'd1);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        expect_v("press_n1_menu", 32'(bus0.is_menu_o), 32'd1);
        tick();
        expect_v("press_n2_play", 32'(bus0.is_playing_o), 32'd1);
        expect_v("entry_rr_high", 32'(bus0.round_reset_o), 32'd1);
        tick();
        expect_v("entry_rr_low", 32'(bus0.round_reset_o), 32'd0);
        start = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0; tick();

        // Target selection and saturation.
        repeat (6) press(1);
        expect_v("target_up_sat", 32'(bus0.target_o), 32'd9);
        repeat (10) press(2);
        expect_v("target_down_sat", 32'(bus0.target_o), 32'd1);
        press(3);
        expect_v("target_both", 32'(bus0.target_o), 32'd1);
        press(1);
        expect_v("target_two", 32'(bus0.target_o), 32'd2);

        // Win 2:0 with pause timing on both instances.
        press(0);
        hit_once(2'b01);
        expect_v("score_1_0", 32'(bus0.score_o), 32'h001);
        expect_v("cont_after_hit", 32'(bus0.is_continue_o), 32'd1);
        frame_tick = 1'b1;
        tick();
        expect_v("nopause_exit", 32'(bus1.is_playing_o), 32'd1);
        tick(); tick();
        expect_v("pause_after_3", 32'(bus0.is_continue_o), 32'd1);
        tick();
        expect_v("pause_exit", 32'(bus0.is_playing_o), 32'd1);
        frame_tick = 1'b0;
        hit_once(2'b01);
        expect_v("score_2_0", 32'(bus0.score_o), 32'h002);
        expect_v("final_2_0", 32'(bus0.is_final_o), 32'd1);
        expect_v("winner_01", 32'(bus0.winner_o), 32'h1);

        // Tie 2:2, with a start-skip out of the pause.
        press(0); press(0);
        hit_once(2'b10);
        expect_v("score_0_1", 32'(bus0.score_o), 32'h040);
        press(0);
        expect_v("skip_play", 32'(bus0.is_playing_o), 32'd1);
        hit_once(2'b01);
        wait_play();
        hit_once(2'b11);
        expect_v("score_2_2", 32'(bus0.score_o), 32'h082);
        expect_v("winner_tie", 32'(bus0.winner_o), 32'h3);

        // Reset in the pause at 3:2.
        press(0);
        repeat (3) press(1);
        press(0);
        hit_once(2'b01); wait_play();
        hit_once(2'b10); wait_play();
        hit_once(2'b01); wait_play();
        hit_once(2'b10); wait_play();
        hit_once(2'b01);
        expect_v("score_3_2", 32'(bus0.score_o), 32'h083);
        expect_v("cont_3_2", 32'(bus0.is_continue_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_v("midreset_menu", 32'(bus0.is_menu_o), 32'd1);
        expect_v("midreset_score", 32'(bus0.score_o), 32'h0);
        expect_v("midreset_target", 32'(bus0.target_o), 32'd5);
        expect_v("midreset_rr", 32'(bus0.round_reset_o), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 5) == 0);
            up         = ($urandom_range(0, 2) == 0);
            down       = ($urandom_range(0, 2) == 0);
            hit        = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
            frame_tick = $urandom_range(0, 1) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/match_fsm.md
# match_fsm

Parametrised match controller for the tank arena, generalising the two-player menu/play/continue/final flow to `NUM_PLAYERS` players. It has a menu-selectable win target, saturating per-player score counters, a frame-counted pause between rounds and a round-reset strobe. It sits beside the video pipeline in the game top. It consumes debounced button levels, per-player hit-credit events and a once-per-frame tick. It drives the state flags used by the renderer, the packed score bus used by the score overlay, and the reset that re-arms map and player blocks.

## Interface
- `NUM_PLAYERS`, 2, number of players (2..8).
- `SCORE_BITS`, 6, width of each score counter.
- `MAX_TARGET`, 9, highest selectable win target; must be ≤ 2^SCORE_BITS−1.
- `DEFAULT_TARGET`, 5, target loaded at reset (1..MAX_TARGET).
- `PAUSE_FRAMES`, 120, frame ticks spent in CONTINUE before the next round.

Ports:
- `clk_i`, in, 1: single clock for the whole block.
- `reset_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: start/confirm button level.
- `sel_up_i`, in, 1: menu up button level.
- `sel_down_i`, in, 1: menu down button level.
- `hit_i`, in, NUM_PLAYERS: bit k high means player k scored a hit this cycle.
- `frame_tick_i`, in, 1: one-cycle pulse per video frame.
- `is_menu_o`, `is_playing_o`, `is_continue_o`, `is_final_o`, out, 1 each: one-hot state flags.
- `round_reset_o`, out, 1: reset for map and player blocks.
- `score_o`, out, NUM_PLAYERS*SCORE_BITS: packed scores, player k at bits [k*SCORE_BITS +: SCORE_BITS].
- `target_o`, out, SCORE_BITS: current win target.
- `winner_o`, out, NUM_PLAYERS: one-hot set of players at or above the target (more than one bit set means a tie); valid in FINAL, zero otherwise.

## Operation
- Button edges:
  - Each button is registered.
  - An edge is `level & ~prev`.
  - `prev` resets to 1, so a button held through reset does not fire.
- States are MENU, PLAYING, CONTINUE and FINAL. Reset state is MENU.
- MENU:
  - Up edge: `target` + 1, saturating at MAX_TARGET.
  - Down edge: `target` − 1, saturating at 1.
  - Up and down edges in the same cycle: no change.
  - Start edge: clear all scores, go to PLAYING. Start takes priority over up/down in the same cycle.
- PLAYING:
  - If any `hit_i` bit is set, each credited player's score increments, saturating at 2^SCORE_BITS−1.
  - Simultaneous hits are all credited.
  - If any updated score ≥ `target`, go to FINAL. Otherwise go to CONTINUE and load the pause counter with PAUSE_FRAMES.
  - Buttons are ignored.
- CONTINUE:
  - `hit_i` is ignored.
  - The counter decrements on each `frame_tick_i`.
  - When the counter is 0, or on a start edge (skip), go to PLAYING.
  - With PAUSE_FRAMES = 0, CONTINUE lasts exactly one cycle.
- FINAL:
  - Scores and `winner_o` hold.
  - Start edge: go to MENU. Scores persist until the next match starts.
- `round_reset_o`:
  - High while `reset_i` is high, and in MENU and FINAL.
  - High for exactly one cycle on each entry into PLAYING.
  - Low otherwise.
- Reset values: MENU flags (`is_menu_o`=1, other flags 0), `round_reset_o`=1, `score_o`=0, `target_o`=DEFAULT_TARGET, `winner_o`=0, pause counter 0.

## Timing
- All outputs are registered. No combinational input-to-output path.
- A button rising in cycle n is sampled at edge n. The edge is seen in cycle n+1, and the state/target change is visible at n+2.
- A hit in cycle n: score and state are visible at n+1.
- A hit coinciding with the PLAYING entry cycle is credited. This cycle is the first PLAYING cycle, with `round_reset_o` high.
- `reset_i` mid-match: the block returns to reset values on the next edge, regardless of state.
- A frame tick and a start edge in the same CONTINUE cycle: the start edge wins; the next state is PLAYING.

## Structure
- `game_pkg` holds:
  - `game_state_t` enum (MENU, PLAYING, CONTINUE, FINAL).
  - A `PAUSE_W` width helper, `$clog2(PAUSE_FRAMES+1)`.
  - Shared score/target width constants reused by the score overlay.
- Sub-module `btn_edge`: registered rising-edge detector with a reset-to-1 history flop. It is instantiated three times.

## Test plan
- Reset with `start_i` held high, then release and press again: no transition on the held press; PLAYING two cycles after the fresh press; `round_reset_o` high for one cycle on entry.
- MENU with DEFAULT_TARGET=5: up ×6 gives `target_o`=9, saturated. Down ×10 gives `target_o`=1. Up and down together: `target_o` unchanged.
- NUM_PLAYERS=2, target 2: `hit_i`=01 gives score 1:0 and CONTINUE. Repeating `hit_i`=01 after the pause gives 2:0, FINAL, `winner_o`=01.
- Score 1:1 with target 2, then `hit_i`=11: 2:2, FINAL, `winner_o`=11 (tie).
- PAUSE_FRAMES=3: CONTINUE exits after the third `frame_tick_i`. With PAUSE_FRAMES=0 it exits after one cycle. A start edge mid-pause exits immediately.
- `reset_i` asserted in CONTINUE with score 3:2: next cycle shows MENU, scores 0, `target_o`=5, `round_reset_o`=1.
